// File: rtl/div_result_collector_pkg.sv
// Shared configuration and coordinate type for the divider output path.
`ifndef max_num_K
`define max_num_K 8
`endif

package div_pkg;

  localparam int unsigned DIV_N         = 8;                        // dividend width
  localparam int unsigned DIV_M         = 4;                        // divisor / remainder width
  localparam int unsigned DIV_NUM_BANKS = 4;                        // accumulator banks
  localparam int unsigned QUOT_W        = DIV_N - DIV_M + 1;        // quotient (row) width
  localparam int unsigned REM_W         = DIV_M;                    // remainder (col) width
  localparam int unsigned KW            = $clog2(`max_num_K) + 1;   // K-tag width
  localparam int unsigned BANK_W        = $clog2(DIV_NUM_BANKS);    // bank select width

  typedef struct packed {
    logic [QUOT_W-1:0] row;
    logic [REM_W-1:0]  col;
    logic [BANK_W-1:0] bank;
    logic [KW-1:0]     k;
  } coord_t;

  // Bank is the low bits of the column index.
  function automatic logic [BANK_W-1:0] bank_of(input logic [REM_W-1:0] rem);
    return rem[BANK_W-1:0];
  endfunction

endpackage

// File: rtl/div_result_collector_if.sv
// Divider-side capture and crossbar-side coordinate handshake.
interface div_result_collector_if;
  import div_pkg::*;

  logic              div_rdy;
  logic [QUOT_W-1:0] div_quotient;
  logic [REM_W-1:0]  div_remainder;
  logic [KW-1:0]     div_k;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [QUOT_W-1:0] out_row;
  logic [REM_W-1:0]  out_col;
  logic [BANK_W-1:0] out_bank;
  logic [KW-1:0]     out_k;

  // Collector side
  modport slave (
    input  div_rdy, div_quotient, div_remainder, div_k, out_ready,
    output busy, out_valid, out_row, out_col, out_bank, out_k
  );

  // Divider + crossbar side
  modport master (
    output div_rdy, div_quotient, div_remainder, div_k, out_ready,
    input  busy, out_valid, out_row, out_col, out_bank, out_k
  );

endinterface

// File: rtl/div_result_fifo.sv
// Generic show-ahead synchronous FIFO; head entry is visible whenever count != 0.
module div_result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != FULL);
  assign do_pop  = pop_i && (count_q != '0);

  // Next pointer/count; flush overrides any concurrent push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Empty FIFO presents zeros so stale entries never leak out.
  assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/div_result_collector.sv
// Buffers divider results and presents them as crossbar coordinates.
module div_result_collector
  import div_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  div_result_collector_if.slave  bus,
  input  logic                   flush,
  output logic [15:0]            result_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  coord_t          wr_coord, rd_coord;
  logic [CW-1:0]   count;
  logic            push, pop;
  logic [15:0]     result_cnt_q, result_cnt_d;

  assign push = bus.div_rdy && !bus.busy;
  assign pop  = bus.out_valid && bus.out_ready;

  // Bank is resolved at capture time and stored with the entry.
  always_comb begin
    wr_coord      = '0;
    wr_coord.row  = bus.div_quotient;
    wr_coord.col  = bus.div_remainder;
    wr_coord.bank = bank_of(bus.div_remainder);
    wr_coord.k    = bus.div_k;
  end

  div_result_fifo #(
    .WIDTH ($bits(coord_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_coord),
    .rdata_o (rd_coord),
    .count_o (count)
  );

  // Stall and handshake derive from occupancy only, never from out_ready.
  always_comb begin
    bus.busy      = (count == FULL);
    bus.out_valid = (count != '0);
    bus.out_row   = rd_coord.row;
    bus.out_col   = rd_coord.col;
    bus.out_bank  = rd_coord.bank;
    bus.out_k     = rd_coord.k;
  end

  // Saturating count of accepted results; flush clears it.
  always_comb begin
    result_cnt_d = result_cnt_q;
    if (flush)                              result_cnt_d = '0;
    else if (push && (result_cnt_q != '1))  result_cnt_d = result_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_cnt_q <= '0;
    else        result_cnt_q <= result_cnt_d;
  end

  assign result_cnt = result_cnt_q;

endmodule

// File: tb/tb_div_result_collector.sv
module tb_div_result_collector;
  import div_pkg::*;

  localparam int DEPTH = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] result_cnt;

  div_result_collector_if bus();

  div_result_collector #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .flush      (flush),
    .result_cnt (result_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int q;
    int r;
    int k;
  } res_t;

  res_t model_q[$];
  int   model_cnt = 0;
  int   drain_log[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model + monitor: sample just before each rising edge, compare
  // DUT against the model queue, then apply that edge's effects to the model.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        model_q.delete();
        model_cnt = 0;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cnt", result_cnt, 0);
      end else begin
        bit full_before;
        full_before = (model_q.size() == DEPTH);
        chk("busy", bus.busy, full_before);
        chk("valid", bus.out_valid, model_q.size() != 0);
        chk("result_cnt", result_cnt, model_cnt);
        if (model_q.size() != 0) begin
          chk("row", bus.out_row, model_q[0].q);
          chk("col", bus.out_col, model_q[0].r);
          chk("bank", bus.out_bank, model_q[0].r % DIV_NUM_BANKS);
          chk("k", bus.out_k, model_q[0].k);
        end
        if (flush) begin
          model_q.delete();
          model_cnt = 0;
        end else begin
          if (model_q.size() != 0 && bus.out_ready) begin
            drain_log.push_back(model_q[0].q);
            void'(model_q.pop_front());
          end
          if (bus.div_rdy && !full_before) begin
            res_t e;
            e.q = int'(bus.div_quotient);
            e.r = int'(bus.div_remainder);
            e.k = int'(bus.div_k);
            model_q.push_back(e);
            if (model_cnt < 65535) model_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    bus.div_rdy = 1'b0;
  endtask

  task automatic drive(input int q, input int r, input int k);
    bus.div_rdy       = 1'b1;
    bus.div_quotient  = QUOT_W'(q);
    bus.div_remainder = REM_W'(r);
    bus.div_k         = KW'(k);
  endtask

  // Present a result like the divider would: hold it until accepted.
  task automatic send(input int q, input int r, input int k);
    int guard;
    drive(q, r, k);
    guard = 0;
    while (bus.busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got busy=%0d expected busy=0", bus.busy);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.div_rdy       = 1'b0;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
    bus.div_k         = '0;
    bus.out_ready     = 1'b0;

    // Reset state
    #1;
    chk("reset_row", bus.out_row, 0);
    chk("reset_col", bus.out_col, 0);
    chk("reset_bank", bus.out_bank, 0);
    chk("reset_k", bus.out_k, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single result: 23 / 5 -> q=4 r=3, k=2
    bus.out_ready = 1'b1;
    send(4, 3, 2);
    idle();
    chk("single_valid", bus.out_valid, 1);
    chk("single_row", bus.out_row, 4);
    chk("single_col", bus.out_col, 3);
    chk("single_bank", bus.out_bank, 3);
    chk("single_k", bus.out_k, 2);
    chk("single_cnt", result_cnt, 1);
    @(negedge clk);
    chk("single_drop", bus.out_valid, 0);

    // Fill and stall
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(i, i, 1);
    idle();
    chk("fill_busy", bus.busy, 1);
    drain_log.delete();
    drive(9, 5, 3);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("stall_busy_fall", bus.busy, 0);
    @(negedge clk);
    idle();
    chk("stall_busy_refill", bus.busy, 1);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("drain_len", drain_log.size(), 5);
    if (drain_log.size() == 5) begin
      chk("drain0", drain_log[0], 0);
      chk("drain1", drain_log[1], 1);
      chk("drain2", drain_log[2], 2);
      chk("drain3", drain_log[3], 3);
      chk("drain4", drain_log[4], 9);
    end

    // Simultaneous push and pop at count 2
    bus.out_ready = 1'b0;
    send(10, 1, 0);
    send(11, 2, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(12 + i, i + 4, i);
      @(negedge clk);
      chk("simul_valid", bus.out_valid, 1);
      chk("simul_busy", bus.busy, 0);
    end
    idle();
    repeat (4) @(negedge clk);

    // Backpressure stability
    bus.out_ready = 1'b0;
    send(21, 13, 5);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_row", bus.out_row, 21);
      chk("hold_col", bus.out_col, 13);
      chk("hold_bank", bus.out_bank, 1);
      chk("hold_k", bus.out_k, 5);
    end
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Flush with a concurrent push
    bus.out_ready = 1'b0;
    send(1, 1, 1);
    send(2, 2, 2);
    send(3, 3, 3);
    drive(30, 7, 4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle();
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_cnt", result_cnt, 0);
    chk("flush_busy", bus.busy, 0);
    @(negedge clk);
    chk("flush_push_dropped", bus.out_valid, 0);

    // Asynchronous reset between edges
    send(5, 6, 7);
    send(6, 7, 8);
    idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", bus.out_valid, 0);
    chk("areset_busy", bus.busy, 0);
    chk("areset_row", bus.out_row, 0);
    chk("areset_col", bus.out_col, 0);
    chk("areset_bank", bus.out_bank, 0);
    chk("areset_k", bus.out_k, 0);
    chk("areset_cnt", result_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Counter saturation
    bus.out_ready = 1'b1;
    force dut.result_cnt_q = 16'hFFFE;
    model_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.result_cnt_q;
    send(1, 1, 1);
    send(2, 2, 2);
    idle();
    chk("sat_cnt", result_cnt, 16'hFFFF);
    send(3, 3, 3);
    idle();
    @(negedge clk);
    chk("sat_hold", result_cnt, 16'hFFFF);

    // Random traffic against the reference model
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.div_rdy       = 1'($urandom_range(0, 1));
      bus.div_quotient  = QUOT_W'($urandom);
      bus.div_remainder = REM_W'($urandom);
      bus.div_k         = KW'($urandom);
      bus.out_ready     = ($urandom_range(0, 3) != 0);
      flush             = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    flush = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("final_empty", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_result_collector.md
Name: div_result_collector

Overview:
- Downstream stage of the pipelined output-coordinate divider: captures quotient/remainder/K-tag from the last divider cell and buffers them in a small FIFO.
- Presents buffered results to the scatter/accumulator-bank crossbar over a valid/ready interface as (row, col, bank, k) coordinates.
- Drives the shared `busy` stall line back into every divider cell when the buffer cannot accept more results.

Parameters:
- N, 8, dividend width of the divider chain
- M, 4, divisor width; remainder width
- DEPTH, 4, FIFO entries; power of two, >=2
- NUM_BANKS, 4, accumulator banks; power of two, <=2^M
- KW, $clog2(`max_num_K)+1, K-tag width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- div_rdy  in  1  last divider cell result valid
- div_quotient  in  N-M+1  final quotient (row index)
- div_remainder  in  M  final remainder (column index)
- div_k  in  KW  K tag from last cell
- busy  out  1  stall to all divider cells
- out_valid  out  1  coordinate available
- out_ready  in  1  crossbar accepts coordinate
- out_row  out  N-M+1  row = quotient
- out_col  out  M  col = remainder
- out_bank  out  $clog2(NUM_BANKS)  col[$clog2(NUM_BANKS)-1:0]
- out_k  out  KW  K tag
- result_cnt  out  16  accepted-result count, saturating at 16'hFFFF
- flush  in  1  synchronous clear of FIFO and counter

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO empty; rd/wr pointers and count cleared.
  - busy=0, out_valid=0, all data outputs 0, result_cnt=0.
  - Reset mid-stream discards all buffered entries.
- push = div_rdy && !busy. pop = out_valid && out_ready.
- busy is combinational from count only: busy = (count==DEPTH). It has no path from out_ready.
- While busy=1, the divider holds its outputs.
  - Cycle N: pop occurs, busy still 1, no push.
  - Cycle N+1: busy=0; the held result is pushed that cycle.
  - No result is lost or duplicated.
- FIFO behaviour:
  - Show-ahead: out_valid = (count!=0). Outputs are driven from the entry at rd_ptr.
  - Latency from push to out_valid is 1 cycle; there is no bypass.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal at any count 1..DEPTH-1.
  - At count==0 only a push is possible.
  - At count==DEPTH only a pop is possible.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0. count is log2(DEPTH)+1 bits.
- Data outputs hold stable while out_valid=1 and out_ready=0.
- Width rules:
  - out_bank is the low bits of the remainder, computed at push time and stored in the FIFO.
  - No arithmetic overflow is possible; values pass through unchanged.
- result_cnt:
  - Increments by 1 on each push.
  - Saturates at 16'hFFFF and does not wrap.
- flush=1 (synchronous):
  - Next edge: count=0, pointers=0, result_cnt=0, out_valid=0.
  - A push in the same cycle is dropped. flush has priority over push and pop.
- Registers reset asynchronously and update on posedge clk. busy, out_valid and out_* are combinational from state.

Decomposition:
- Shared package div_pkg:
  - constants for quotient width, remainder width and KW derived from N/M/`max_num_K;
  - typedef struct packed coord_t {row, col, bank, k} used by the crossbar and this block.
- One sub-module: div_result_fifo, a generic show-ahead sync FIFO parameterised by width and DEPTH.
  - The collector instantiates it with coord_t.
  - The collector adds the busy/push logic, the bank extraction and the counter.

Test Plan:
- Single result: dividend 23 / divisor 5 reaches the last cell (div_rdy=1, quotient=4, remainder=3, k=2), out_ready=1 -> next cycle out_valid=1, row=4, col=3, bank=3, k=2; result_cnt=1; valid drops after the pop.
- Fill and stall: out_ready=0, 4 back-to-back results (q=0..3) -> busy=1 after the 4th push. A 5th result (q=9) is held by the divider. Raise out_ready for 1 cycle -> q=0 popped, busy falls, q=9 is pushed the next cycle. Drain order is 1, 2, 3, 9.
- Simultaneous push and pop: count=2, div_rdy=1 and out_ready=1 for 6 cycles -> count stays 2, in-order output, pointers wrap, no loss.
- Backpressure stability: out_valid=1, out_ready=0 for 5 cycles -> row/col/bank/k unchanged each cycle.
- Flush and async reset:
  - flush with 3 entries plus a concurrent div_rdy -> count=0, result_cnt=0, out_valid=0, pushed value absent.
  - rst_n pulsed low between clock edges -> all outputs 0 immediately.
- Counter saturation: preload or force result_cnt=16'hFFFE, two pushes -> 16'hFFFF, stays 16'hFFFF.
